// File: rtl/cond_unit.sv
// Condition/flag stage: evaluates the condition field against the NZCV register,
// gates the decoder write requests, and keeps saturating cycle/fetch/squash counters.
module cond_unit #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       Cond,
  input  logic [3:0]       ALUFlags,
  input  logic [1:0]       FlagW,
  input  logic             PCS,
  input  logic             NextPC,
  input  logic             RegW,
  input  logic             MemW,
  input  logic             clr_cnt,
  output logic             PCWrite,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic [3:0]       Flags,
  output logic             CondExR,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] fetch_cnt,
  output logic [CNT_W-1:0] squash_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [3:0]       flags_r;
  logic             cond_exr_r;
  logic             squashed_r;
  logic [CNT_W-1:0] cyc_cnt_r;
  logic [CNT_W-1:0] fetch_cnt_r;
  logic [CNT_W-1:0] squash_cnt_r;

  logic cond_ex_s;
  logic req_s;
  logic squash_ev_s;
  logic n_s, z_s, c_s, v_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
    return (val == CNT_MAX) ? val : val + CNT_ONE;
  endfunction

  // Condition evaluation against the current flag register
  always_comb begin
    {n_s, z_s, c_s, v_s} = flags_r;
    cond_ex_s = 1'b0;
    case (Cond)
      4'b0000: cond_ex_s = z_s;
      4'b0001: cond_ex_s = ~z_s;
      4'b0010: cond_ex_s = c_s;
      4'b0011: cond_ex_s = ~c_s;
      4'b0100: cond_ex_s = n_s;
      4'b0101: cond_ex_s = ~n_s;
      4'b0110: cond_ex_s = v_s;
      4'b0111: cond_ex_s = ~v_s;
      4'b1000: cond_ex_s = c_s & ~z_s;
      4'b1001: cond_ex_s = ~c_s | z_s;
      4'b1010: cond_ex_s = (n_s == v_s);
      4'b1011: cond_ex_s = (n_s != v_s);
      4'b1100: cond_ex_s = ~z_s & (n_s == v_s);
      4'b1101: cond_ex_s = z_s | (n_s != v_s);
      4'b1110: cond_ex_s = 1'b1;
      4'b1111: cond_ex_s = 1'b1;
      default: cond_ex_s = 1'b0;
    endcase
  end

  // A squash is counted only once per instruction; squashed_r remembers it until the next fetch
  assign req_s       = RegW | MemW | PCS | (FlagW != 2'b00);
  assign squash_ev_s = req_s & ~cond_exr_r & ~squashed_r;

  // Enables are forced low while reset is held, independent of the clock
  assign PCWrite    = reset & ((PCS & cond_exr_r) | NextPC);
  assign RegWrite   = reset & RegW & cond_exr_r;
  assign MemWrite   = reset & MemW & cond_exr_r;
  assign Flags      = flags_r;
  assign CondExR    = cond_exr_r;
  assign cyc_cnt    = cyc_cnt_r;
  assign fetch_cnt  = fetch_cnt_r;
  assign squash_cnt = squash_cnt_r;

  // Flag register, registered condition result and squash marker
  always_ff @(posedge clk) begin
    if (!reset) begin
      flags_r    <= 4'b0000;
      cond_exr_r <= 1'b0;
      squashed_r <= 1'b0;
    end else begin
      cond_exr_r <= cond_ex_s;
      if (FlagW[1] & cond_exr_r) flags_r[3:2] <= ALUFlags[3:2];
      if (FlagW[0] & cond_exr_r) flags_r[1:0] <= ALUFlags[1:0];
      if (NextPC) begin
        squashed_r <= 1'b0;
      end else if (squash_ev_s) begin
        squashed_r <= 1'b1;
      end
    end
  end

  // Saturating performance counters; clear overrides any increment
  always_ff @(posedge clk) begin
    if (!reset) begin
      cyc_cnt_r    <= CNT_ZERO;
      fetch_cnt_r  <= CNT_ZERO;
      squash_cnt_r <= CNT_ZERO;
    end else if (clr_cnt) begin
      cyc_cnt_r    <= CNT_ZERO;
      fetch_cnt_r  <= CNT_ZERO;
      squash_cnt_r <= CNT_ZERO;
    end else begin
      cyc_cnt_r <= sat_inc(cyc_cnt_r);
      if (NextPC)      fetch_cnt_r  <= sat_inc(fetch_cnt_r);
      if (squash_ev_s) squash_cnt_r <= sat_inc(squash_cnt_r);
    end
  end

endmodule

// File: tb/tb_cond_unit.sv
// Directed bench for cond_unit (CNT_W=4 so saturation is reachable quickly).
module tb_cond_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       PCS, NextPC, RegW, MemW, clr_cnt;
  logic       PCWrite, RegWrite, MemWrite, CondExR;
  logic [3:0] Flags;
  logic [3:0] cyc_cnt, fetch_cnt, squash_cnt;

  int check_count = 0;
  int error_count = 0;

  cond_unit #(.CNT_W(4)) dut (
    .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
    .PCS(PCS), .NextPC(NextPC), .RegW(RegW), .MemW(MemW), .clr_cnt(clr_cnt),
    .PCWrite(PCWrite), .RegWrite(RegWrite), .MemWrite(MemWrite), .Flags(Flags),
    .CondExR(CondExR), .cyc_cnt(cyc_cnt), .fetch_cnt(fetch_cnt), .squash_cnt(squash_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    check_count++;
    if (got !== exp) begin
      error_count++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // 1: reset held with every request asserted
    reset = 1'b0; Cond = 4'b1110; ALUFlags = 4'b1111; FlagW = 2'b11;
    PCS = 1'b1; NextPC = 1'b1; RegW = 1'b1; MemW = 1'b1; clr_cnt = 1'b0;
    step(); step();
    check_eq("rst_pcwrite",  8'(PCWrite),    8'd0);
    check_eq("rst_regwrite", 8'(RegWrite),   8'd0);
    check_eq("rst_memwrite", 8'(MemWrite),   8'd0);
    check_eq("rst_flags",    8'(Flags),      8'h0);
    check_eq("rst_condexr",  8'(CondExR),    8'd0);
    check_eq("rst_cyc",      8'(cyc_cnt),    8'd0);
    check_eq("rst_fetch",    8'(fetch_cnt),  8'd0);
    check_eq("rst_squash",   8'(squash_cnt), 8'd0);

    // 2: AL writes flags 1010, then MI executes
    reset = 1'b1; FlagW = 2'b00; PCS = 1'b0; NextPC = 1'b0; RegW = 1'b0; MemW = 1'b0;
    step();
    FlagW = 2'b11; ALUFlags = 4'b1010;
    step();
    check_eq("al_flags", 8'(Flags),   8'hA);
    check_eq("al_cyc",   8'(cyc_cnt), 8'd2);
    FlagW = 2'b00; Cond = 4'b0100; RegW = 1'b1;
    step(); step();
    check_eq("mi_condexr",  8'(CondExR),  8'd1);
    check_eq("mi_regwrite", 8'(RegWrite), 8'd1);
    check_eq("mi_pcwrite",  8'(PCWrite),  8'd0);

    // 3: Z set, NE fails, request spans two cycles -> one squash
    RegW = 1'b0; Cond = 4'b1110; FlagW = 2'b11; ALUFlags = 4'b0100;
    step();
    check_eq("z_flags", 8'(Flags), 8'h4);
    FlagW = 2'b00; Cond = 4'b0001;
    #1;
    check_eq("ne_latency", 8'(CondExR), 8'd1);
    step();
    check_eq("ne_condexr", 8'(CondExR), 8'd0);
    RegW = 1'b1; MemW = 1'b1;
    #1;
    check_eq("ne_regwrite", 8'(RegWrite), 8'd0);
    check_eq("ne_memwrite", 8'(MemWrite), 8'd0);
    step(); step();
    check_eq("ne_squash", 8'(squash_cnt), 8'd1);

    // 4: independent flag halves
    RegW = 1'b0; MemW = 1'b0; Cond = 4'b1110;
    step();
    FlagW = 2'b11; ALUFlags = 4'b1000;
    step();
    check_eq("n_flags", 8'(Flags), 8'h8);
    FlagW = 2'b10; ALUFlags = 4'b0011;
    step();
    check_eq("nz_only", 8'(Flags), 8'h0);
    FlagW = 2'b01;
    step();
    check_eq("cv_only", 8'(Flags), 8'h3);

    // 5: EQ fails but NextPC forces the PC write; squash marker cleared by fetch
    FlagW = 2'b00; Cond = 4'b0000; NextPC = 1'b1;
    step();
    PCS = 1'b1;
    #1;
    check_eq("eq_pcwrite_next", 8'(PCWrite), 8'd1);
    step();
    check_eq("eq_squash_fetch", 8'(squash_cnt), 8'd2);
    NextPC = 1'b0;
    #1;
    check_eq("eq_pcwrite_nonext", 8'(PCWrite), 8'd0);
    step();
    check_eq("eq_squash_after", 8'(squash_cnt), 8'd3);
    step();
    check_eq("eq_squash_once", 8'(squash_cnt), 8'd3);

    // 6: clear, then saturate all three counters at 15
    clr_cnt = 1'b1;
    step();
    check_eq("clr_cyc",    8'(cyc_cnt),    8'd0);
    check_eq("clr_fetch",  8'(fetch_cnt),  8'd0);
    check_eq("clr_squash", 8'(squash_cnt), 8'd0);
    clr_cnt = 1'b0; NextPC = 1'b1;
    for (int i = 0; i < 20; i++) step();
    check_eq("sat_cyc",    8'(cyc_cnt),    8'd15);
    check_eq("sat_fetch",  8'(fetch_cnt),  8'd15);
    check_eq("sat_squash", 8'(squash_cnt), 8'd15);
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    check_eq("clr2_cyc",    8'(cyc_cnt),    8'd0);
    check_eq("clr2_fetch",  8'(fetch_cnt),  8'd0);
    check_eq("clr2_squash", 8'(squash_cnt), 8'd0);
    check_eq("clr2_flags",  8'(Flags),      8'h3);
    check_eq("clr2_condexr", 8'(CondExR),   8'd0);

    // 7: reset mid-instruction
    reset = 1'b0; RegW = 1'b1; MemW = 1'b1;
    step();
    check_eq("mid_flags",   8'(Flags),   8'h0);
    check_eq("mid_cyc",     8'(cyc_cnt), 8'd0);
    check_eq("mid_pcwrite", 8'(PCWrite), 8'd0);
    check_eq("mid_regwrite", 8'(RegWrite), 8'd0);
    reset = 1'b1;
    step();
    check_eq("post_cyc", 8'(cyc_cnt), 8'd1);

    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

endmodule
